twos_to_signmag_serial: RTL and testbench

- Bit-serial converter from SIZE-bit two's-complement to sign-magnitude: the decode direction of the ALU's two's-complement negation path.
- Feeds the display/result-formatting stage downstream of the 8-bit ALU.
- Processes one bit per clock, LSB first, using the copy-until-first-one-then-invert rule.
- Valid/ready handshake on both input and output.

---
 rtl/twos_to_signmag_serial.sv | 96 +++++++++
 tb/tb_twos_to_signmag_serial.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/twos_to_signmag_serial.sv
// Bit-serial two's-complement to sign-magnitude converter, LSB first.
// Bits are copied up to and including the first 1, then inverted, but only for negative operands.
module twos_to_signmag_serial #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] a,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            sign,
  output logic [SIZE-1:0] mag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic [1:0]      dbg_state_o
);

  localparam int CNT_W = $clog2(SIZE);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SIZE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SIZE-1:0]  src_q, src_d;
  logic [SIZE-1:0]  mag_q, mag_d;
  logic             sign_q, sign_d;
  logic             seen_q, seen_d;
  logic             out_bit;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; the input side is ready only in IDLE and the output side is
  // valid only in DONE, so an operand and its result never overlap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
      mag_q   <= '0;
      sign_q  <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      mag_q   <= mag_d;
      sign_q  <= sign_d;
      seen_q  <= seen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    mag_d   = mag_q;
    sign_d  = sign_q;
    seen_d  = seen_q;
    out_bit = (sign_q & seen_q) ? ~src_q[0] : src_q[0];
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          src_d   = a;
          sign_d  = a[SIZE-1];
          seen_d  = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        seen_d = seen_q | src_q[0];
        mag_d  = {out_bit, mag_q[SIZE-1:1]};
        src_d  = src_q >> 1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign sign        = sign_q;
  assign mag         = mag_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_twos_to_signmag_serial.sv
// Directed bench for twos_to_signmag_serial: SIZE=8 and SIZE=4 instances on a shared clock/reset.
module tb_twos_to_signmag_serial;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] a8 = '0;
  logic       in_valid8 = 1'b0, out_ready8 = 1'b0;
  logic       in_ready8, sign8, out_valid8, busy8;
  logic [7:0] mag8;
  logic [1:0] st8;

  logic [3:0] a4 = '0;
  logic       in_valid4 = 1'b0, out_ready4 = 1'b0;
  logic       in_ready4, sign4, out_valid4, busy4;
  logic [3:0] mag4;
  logic [1:0] st4;

  twos_to_signmag_serial #(.SIZE(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .in_valid(in_valid8), .in_ready(in_ready8),
    .sign(sign8), .mag(mag8), .out_valid(out_valid8), .out_ready(out_ready8),
    .busy(busy8), .dbg_state_o(st8)
  );

  twos_to_signmag_serial #(.SIZE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .in_valid(in_valid4), .in_ready(in_ready4),
    .sign(sign4), .mag(mag4), .out_valid(out_valid4), .out_ready(out_ready4),
    .busy(busy4), .dbg_state_o(st4)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // ---------------- SIZE=8 driver tasks ----------------
  task automatic start8(input logic [7:0] v);
    @(negedge clk);
    check("in_ready8_before_accept", in_ready8, 1);
    a8 = v;
    in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    a8 = 8'($urandom_range(0, 255));
    check("busy8_after_accept", busy8, 1);
    check("state8_shift", st8, 2'd1);
  endtask

  task automatic wait8(input int exp_lat);
    int cyc = 0;
    while (!out_valid8 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency8", cyc, exp_lat);
  endtask

  task automatic result8(input logic s, input logic [7:0] m);
    check("sign8", sign8, s);
    check("mag8", mag8, m);
    check("in_ready8_in_done", in_ready8, 0);
  endtask

  task automatic handshake8;
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    check("out_valid8_after_hs", out_valid8, 0);
    check("in_ready8_after_hs", in_ready8, 1);
    check("busy8_after_hs", busy8, 0);
  endtask

  // ---------------- SIZE=4 driver task ----------------
  task automatic run4(input logic [3:0] v, input logic s, input logic [3:0] m);
    int cyc = 0;
    @(negedge clk);
    a4 = v;
    in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    a4 = 4'($urandom_range(0, 15));
    while (!out_valid4 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency4", cyc, 4);
    check("sign4", sign4, s);
    check("mag4", mag4, m);
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
    check("in_ready4_after_hs", in_ready4, 1);
  endtask

  initial begin
    int spurious;
    #12;
    check("rst_in_ready8", in_ready8, 1);
    check("rst_out_valid8", out_valid8, 0);
    check("rst_busy8", busy8, 0);
    check("rst_sign8", sign8, 0);
    check("rst_mag8", mag8, 0);
    check("rst_state8", st8, 2'd0);
    check("rst_in_ready4", in_ready4, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // zero with out_ready held high throughout (ignored outside DONE)
    out_ready8 = 1'b1;
    start8(8'h00);
    wait8(8);
    result8(1'b0, 8'h00);
    handshake8();

    start8(8'h05); wait8(8); result8(1'b0, 8'h05); handshake8();
    start8(8'hFB); wait8(8); result8(1'b1, 8'h05); handshake8();
    start8(8'hFF); wait8(8); result8(1'b1, 8'h01); handshake8();
    start8(8'h80); wait8(8); result8(1'b1, 8'h80); handshake8();
    start8(8'h7F); wait8(8); result8(1'b0, 8'h7F); handshake8();

    // backpressure with an ignored in_valid, then both high in DONE
    start8(8'hC4);
    wait8(8);
    result8(1'b1, 8'h3C);
    a8 = 8'h01;
    in_valid8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid8", out_valid8, 1);
      check("bp_sign8", sign8, 1);
      check("bp_mag8", mag8, 8'h3C);
      check("bp_in_ready8", in_ready8, 0);
    end
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    check("bp_hs_out_valid8", out_valid8, 0);
    check("bp_hs_state8_idle", st8, 2'd0);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    check("bp_late_accept_busy8", busy8, 1);
    wait8(8);
    result8(1'b0, 8'h01);
    handshake8();

    // asynchronous reset in the middle of SHIFT
    start8(8'h9C);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_sign8", sign8, 0);
    check("mid_rst_mag8", mag8, 0);
    check("mid_rst_out_valid8", out_valid8, 0);
    check("mid_rst_in_ready8", in_ready8, 1);
    check("mid_rst_busy8", busy8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid8) spurious++;
    end
    check("no_spurious_out_valid8", spurious, 0);
    start8(8'hF0); wait8(8); result8(1'b1, 8'h10); handshake8();

    // SIZE=4 instance
    run4(4'h4, 1'b0, 4'h4);
    run4(4'h1, 1'b0, 4'h1);
    run4(4'h6, 1'b0, 4'h6);
    run4(4'h7, 1'b0, 4'h7);
    run4(4'hC, 1'b1, 4'h4);
    run4(4'h8, 1'b1, 4'h8);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
